// File: rtl/sigdel_pkg.sv
// Shared sizing for the sigma-delta decimator and its CIC stages.
// Latency: none (constants and sizing functions only).
// Backpressure: not applicable.
package sigdel_pkg;

  localparam int SIGDEL_OUT_W  = 8;
  localparam int SIGDEL_LOG2_R = 8;

  // Internal CIC word width: large enough that the final comb output
  // (at most R^K) is represented exactly, given modulo-2^W arithmetic.
  function automatic int sigdel_word_w(input int k, input int log2_r);
    return k * log2_r + 1;
  endfunction

  // Right shift that maps the full-scale raw result R^K onto OUT_W bits.
  function automatic int sigdel_out_shift(input int k, input int log2_r, input int out_w);
    return k * log2_r - out_w;
  endfunction

endpackage

// File: rtl/sigdel_cic_stage.sv
// One CIC integrator plus one comb, both W bits wide, arithmetic modulo 2^W.
// Latency: integrator registered; comb output is combinational from comb_in.
// Backpressure: none; int_en (bit_vld) and comb_en (dec) stall each half.
module sigdel_cic_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         int_en,
  input  logic         comb_en,
  input  logic [W-1:0] int_in,
  input  logic [W-1:0] comb_in,
  output logic [W-1:0] acc,
  output logic [W-1:0] comb_out
);

  logic [W-1:0] z;

  // Comb difference against the value captured at the previous decimation.
  assign comb_out = comb_in - z;

  // Integrator advances on every valid bit; comb delay loads on decimation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      z   <= '0;
    end else begin
      if (int_en)  acc <= acc + int_in;
      if (comb_en) z   <= comb_in;
    end
  end

endmodule

// File: rtl/sigdel_decim.sv
// Sigma-delta bitstream to PCM decoder: sinc-K CIC decimator, ratio 2^LOG2_R.
// Latency: sample registered on the edge consuming the R-th valid bit.
// Backpressure: none; bit_vld=0 freezes all state. Macro SIGDEL_DECIM_SINC2_EN selects K=2.
module sigdel_decim
  import sigdel_pkg::*;
#(
  parameter int LOG2_R = SIGDEL_LOG2_R,
  parameter int OUT_W  = SIGDEL_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_vld,
  output logic             pcm_sat
);

`ifdef SIGDEL_DECIM_SINC2_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif
  localparam int W     = sigdel_word_w(K, LOG2_R);
  localparam int SHIFT = sigdel_out_shift(K, LOG2_R, OUT_W);
  localparam logic [OUT_W-1:0] PCM_MAX = '1;

  logic [LOG2_R-1:0] cnt;
  logic              dec;
  logic              emit;
  logic [W-1:0]      bit_ext;
  logic [W-1:0]      acc_top_nxt;
  logic [W-1:0]      raw;
  logic [W-1:0]      scaled;
  logic              sat_c;

  assign bit_ext = {{(W-1){1'b0}}, bit_in};
  assign dec     = bit_vld && (cnt == {LOG2_R{1'b1}});

`ifdef SIGDEL_DECIM_SINC2_EN
  logic [W-1:0] acc1, acc2, c1, c2;
  logic         warm_q;

  // Top integrator value including the bit consumed this cycle.
  assign acc_top_nxt = acc2 + acc1;

  sigdel_cic_stage #(.W(W)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_en   (bit_vld),
    .comb_en  (dec),
    .int_in   (bit_ext),
    .comb_in  (acc_top_nxt),
    .acc      (acc1),
    .comb_out (c1)
  );

  sigdel_cic_stage #(.W(W)) u_stage2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_en   (bit_vld),
    .comb_en  (dec),
    .int_in   (acc1),
    .comb_in  (c1),
    .acc      (acc2),
    .comb_out (c2)
  );

  assign raw  = c2;
  assign emit = dec && warm_q;

  // First decimation after reset only primes the comb delays.
  always_ff @(posedge clk) begin
    if (!rst_n)   warm_q <= 1'b0;
    else if (dec) warm_q <= 1'b1;
  end
`else
  logic [W-1:0] acc1, c1;

  assign acc_top_nxt = acc1 + bit_ext;

  sigdel_cic_stage #(.W(W)) u_stage1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_en   (bit_vld),
    .comb_en  (dec),
    .int_in   (bit_ext),
    .comb_in  (acc_top_nxt),
    .acc      (acc1),
    .comb_out (c1)
  );

  assign raw  = c1;
  assign emit = dec;
`endif

  // Full scale R^K lands one past PCM_MAX after scaling, so it must clamp.
  assign scaled = raw >> SHIFT;
  assign sat_c  = scaled > {{(W-OUT_W){1'b0}}, PCM_MAX};

  // Position within the current decimation window.
  always_ff @(posedge clk) begin
    if (!rst_n)       cnt <= '0;
    else if (bit_vld) cnt <= cnt + LOG2_R'(1);
  end

  // Output register: pcm_out holds between samples, strobes pulse once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcm_out <= '0;
      pcm_vld <= 1'b0;
      pcm_sat <= 1'b0;
    end else begin
      pcm_vld <= emit;
      pcm_sat <= emit && sat_c;
      if (emit) pcm_out <= sat_c ? PCM_MAX : scaled[OUT_W-1:0];
    end
  end

endmodule

// File: doc/sigdel_decim.md
Name: sigdel_decim

Overview:
- Decoder for the 1-bit sigma-delta bitstream produced by the team's `sigdel` modulator.
- Recovers 8-bit PCM samples using a CIC (sinc-K) decimator with ratio R = 2^LOG2_R.
- Sits in the TinyTapeout top between a bitstream input pin (ui_in[0]) and the PCM output bus (uo_out).
- Output strobe lets downstream logic or a loopback checker capture each decimated sample.

Parameters:
- LOG2_R, 8, log2 of decimation ratio; legal range OUT_W..12.
- OUT_W, 8, PCM output width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- bit_in  input  1  sigma-delta bitstream; 1 = +full scale, 0 = zero.
- bit_vld  input  1  qualifies bit_in; logic advances only when high.
- pcm_out  output  OUT_W  decimated PCM sample.
- pcm_vld  output  1  one-cycle pulse; pcm_out is new this cycle.
- pcm_sat  output  1  high with pcm_vld when the sample was clamped.

Behaviour:
- Reset:
  - Sampled on clk edge while rst_n=0.
  - Clears integrators, comb delays, sample counter cnt and warm-up counter.
  - pcm_out=0, pcm_vld=0, pcm_sat=0.
  - Reset mid-period discards the partial sum; warm-up restarts.
- Order and width:
  - K = 2 when SIGDEL_DECIM_SINC2_EN is defined, else K = 1.
  - Internal word width W = K*LOG2_R+1.
  - All integrator/comb arithmetic is unsigned modulo 2^W; wrap is intentional and exact.
- Integrators, on each cycle with bit_vld=1:
  - acc1 <= acc1 + bit_in.
  - K=2 only: acc2 <= acc2 + acc1 (old acc1 value).
- Sample counter:
  - cnt (LOG2_R bits) increments on bit_vld and wraps from R-1 to 0.
  - dec = bit_vld & (cnt == R-1).
- Comb, on dec only, using acc_top = acc1 (K=1) or acc2 (K=2):
  - c1 = acc_top_next - z1; z1 <= acc_top_next.
  - K=2 only: c2 = c1 - z2; z2 <= c1.
  - acc_top_next is the integrator value including the current bit.
- Raw result:
  - raw = c1 (K=1) or c2 (K=2), range 0..R^K.
  - scaled = raw >> (K*LOG2_R - OUT_W).
- Saturation: if scaled > 2^OUT_W-1, then pcm_out <= 2^OUT_W-1 and pcm_sat <= 1; else pcm_out <= scaled and pcm_sat <= 0.
- Latency: pcm_out, pcm_vld and pcm_sat register on the same edge that consumes the R-th valid bit, so they are visible the following cycle.
- Warm-up:
  - The first K-1 dec events after reset update the comb state only.
  - pcm_vld stays 0 for those events; pcm_out holds 0.
  - K=1 has no warm-up.
- pcm_vld:
  - Exactly one cycle per emitted sample.
  - Low in all other cycles, including while bit_vld=0.
- bit_vld=0 for any duration:
  - Holds all state.
  - pcm_out holds its last value.

Optional Feature:
- Macro: SIGDEL_DECIM_SINC2_EN.
- Defined: second-order CIC (K=2, two integrators, two combs, one warm-up period); better quantisation-noise rejection.
- Undefined: first-order boxcar (K=1), which counts the ones in each R-bit window; no acc2/z2 registers, no warm-up.
- Ports and scaling rule are identical in both builds.

Decomposition:
- Package sigdel_pkg holds:
  - SIGDEL_OUT_W = 8 and SIGDEL_LOG2_R = 8 defaults.
  - A function computing W from K and LOG2_R.
  - A function computing the output shift.
- One natural sub-module, sigdel_cic_stage: a parameterised integrator+comb pair of width W.
  - Instantiated K times.
  - Stage 1 takes a zero-extended bit_in.
  - Stage n's integrator feeds from stage n-1's integrator.
  - Its comb chains from stage n-1's comb output.
- Top-level decimator owns cnt, warm-up, scaling and saturation.

Test Plan (defaults LOG2_R=8, OUT_W=8; run both macro builds):
- Reset then 3*256 cycles of bit_in=0, bit_vld=1 -> every emitted pcm_out=0, pcm_sat=0; first pcm_vld after 256 valid bits (K=1) or 512 (K=2).
- Constant bit_in=1 -> emitted pcm_out=255 with pcm_sat=1 (raw 256 or 65536 clamped).
- Alternating 1,0 pattern -> steady-state pcm_out=128, pcm_sat=0; pcm_vld spacing exactly 256 cycles.
- bit_vld toggled 1-of-3 cycles with a 1,1,0,0 pattern -> pcm_out=128; pcm_vld spacing 768 cycles; outputs frozen while bit_vld=0.
- Assert rst_n=0 for one cycle mid-window (after 100 valid bits of 1s) -> next cycle pcm_out=0, pcm_vld=0; next pcm_vld exactly 256/512 valid bits after reset release.
- Loopback from the `sigdel` modulator with inp=64 for 4096 cycles -> K=2 emitted samples within 64±1 after warm-up.
